serial_addsub: RTL and testbench

//  Bit-serial WIDTH-bit adder/subtractor with a start/done handshake. One result bit per cycle, LSB first.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/serial_fa.sv | 18 +
 rtl/serial_addsub.sv | 174 +++++++++++++++++
 tb/tb_serial_addsub.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : FSM state encoding (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB : values of the 'sub' request bit
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_fa.sv
// 1-bit combinational full adder, reused once per cycle by serial_addsub.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out (majority of a, b, ci)
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with a start/done handshake.
// One result bit is produced per cycle, LSB first, through a single
// shared full adder. Results match a combinational ripple adder for the
// same a, b and cin.
//
// Optional feature macro: SERIAL_ADDSUB_FLAGS_EN adds the zero and ovf
// flag outputs. Without it those ports and their logic do not exist.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE or DONE
//   sub    : 0 -> z = a + b + cin, 1 -> z = a - b - cin (cin is borrow-in)
//   a, b   : operands, captured when start is accepted
//   cin    : carry-in / borrow-in, captured with the operands
//   busy   : high while result bits are being computed
//   done   : one-cycle pulse, z/cout valid
//   z      : result, only updated when the last bit is computed
//   cout   : final carry; in subtract mode 1 means no borrow
//   zero   : (flags build) z == 0
//   ovf    : (flags build) two's-complement signed overflow
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout
`ifdef SERIAL_ADDSUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             run;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [WIDTH-2:0] partial;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] shift_next;

  serial_fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // The partial register only needs WIDTH-1 bits: the final sum bit goes
  // straight into z on the last cycle together with the earlier bits.
  assign shift_next = {fa_s, partial};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    run        = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        run  = 1'b1;
        if (cnt == LAST_BIT) begin
          last       = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = S_RUN;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: subtraction is done as a + ~b + ~cin, so the operand and
  // carry are inverted once at capture and the adder itself never changes.
  // z/cout are written only on the final bit so partial results stay hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      partial <= '0;
      cnt     <= '0;
      z       <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      cnt  <= '0;
      case (sub)
        OP_ADD: begin
          b_sr  <= b;
          carry <= cin;
        end
        OP_SUB: begin
          b_sr  <= ~b;
          carry <= ~cin;
        end
      endcase
    end else if (run) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry   <= fa_co;
      partial <= shift_next[WIDTH-1:1];
      cnt     <= cnt + 1'b1;
      if (last) begin
        z    <= shift_next;
        cout <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADDSUB_FLAGS_EN
  // On the last bit, 'carry' is the carry into the MSB and fa_co the
  // carry out of it; their difference is signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (run && last) begin
      zero <= (shift_next == '0);
      ovf  <= carry ^ fa_co;
    end
  end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH = 32).
// Directed cases cover reset, add/sub, wrap-around, overflow, handshake
// corner cases and reset mid-operation; then 1000 random operations are
// checked against an arithmetic reference model. Flag outputs are checked
// only when SERIAL_ADDSUB_FLAGS_EN is defined.
module tb_serial_addsub;

  localparam int WIDTH = 32;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic             cin   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .cout  (cout)
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the DUT stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^WIDTH.
  // Carry-out for add means the true sum reached 2^WIDTH; for subtract it
  // means the true difference was not negative. Overflow means the signed
  // true result lies outside the WIDTH-bit signed range.
  function automatic void refModel(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic cv, input logic sv,
                                   output logic [WIDTH-1:0] zv, output logic cov,
                                   output logic zerov, output logic ovfv);
    longint ua, ub, uc, full, sa, sb, sres;
    longint smax, smin;
    ua   = longint'(av);
    ub   = longint'(bv);
    uc   = longint'(cv);
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    if (sv) begin
      full = ua - ub - uc;
      cov  = (full >= 0);
      sres = sa - sb - uc;
    end else begin
      full = ua + ub + uc;
      cov  = (full >= (longint'(1) <<< WIDTH));
      sres = sa + sb + uc;
    end
    zv    = full[WIDTH-1:0];
    zerov = (zv == '0);
    ovfv  = (sres > smax) || (sres < smin);
  endfunction

  // Called at a falling edge; start is sampled at the following rising
  // edge. Operand pins are scrambled afterwards to prove they were latched.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input logic sv);
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cin   = 1'($urandom_range(0, 1));
    sub   = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < WIDTH + 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic cv, input logic sv);
    logic [WIDTH-1:0] ez;
    logic             ec;
    logic             ezero;
    logic             eovf;
    refModel(av, bv, cv, sv, ez, ec, ezero, eovf);
    checkOutput({tag, "_z"}, 64'(z), 64'(ez));
    checkOutput({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDSUB_FLAGS_EN
    checkOutput({tag, "_zero"}, 64'(zero), 64'(ezero));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(eovf));
`endif
  endtask

  // One full operation: accept, latency WIDTH+1 edges counting the accept
  // edge, then result check in the done cycle.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic cv, input logic sv);
    int n;
    applyStimulus(av, bv, cv, sv);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    checkOutput({tag, "_done_low"}, 64'(done), 64'd0);
    waitDone(n);
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_latency"}, 64'(n + 1), 64'(WIDTH + 1));
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkResult(tag, av, bv, cv, sv);
  endtask

  initial begin
    int               n;
    int               done_count;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_z", 64'(z), 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDSUB_FLAGS_EN
    checkOutput("reset_zero", 64'(zero), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Simple add
    runOp("t1_add", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    checkOutput("t1_z_const", 64'(z), 64'h8);
    checkOutput("t1_cout_const", 64'(cout), 64'd0);
    @(negedge clk);
    checkOutput("t1_done_pulse", 64'(done), 64'd0);
    checkOutput("t1_z_hold", 64'(z), 64'h8);

    // Wrap-around add
    runOp("t2_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    checkOutput("t2_z_const", 64'(z), 64'h0);
    checkOutput("t2_cout_const", 64'(cout), 64'd1);
`ifdef SERIAL_ADDSUB_FLAGS_EN
    checkOutput("t2_zero_const", 64'(zero), 64'd1);
    checkOutput("t2_ovf_const", 64'(ovf), 64'd0);
`endif

    // Subtract with borrow-in, then a borrowing subtract back-to-back
    runOp("t3_sub", 32'd10, 32'd3, 1'b1, 1'b1);
    checkOutput("t3_z_const", 64'(z), 64'd6);
    checkOutput("t3_cout_const", 64'(cout), 64'd1);
    runOp("t3_borrow", 32'd0, 32'd1, 1'b0, 1'b1);
    checkOutput("t3b_z_const", 64'(z), 64'hFFFF_FFFF);
    checkOutput("t3b_cout_const", 64'(cout), 64'd0);

    // Signed overflow
    runOp("t4_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    checkOutput("t4_z_const", 64'(z), 64'h8000_0000);
`ifdef SERIAL_ADDSUB_FLAGS_EN
    checkOutput("t4_ovf_const", 64'(ovf), 64'd1);
    checkOutput("t4_zero_const", 64'(zero), 64'd0);
`endif

    // Start pulsed while busy must be ignored
    @(negedge clk);
    applyStimulus(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    a     = 32'h0000_FFFF;
    b     = 32'h0000_0001;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(n);
    checkOutput("t5_done", 64'(done), 64'd1);
    checkOutput("t5_latency", 64'(n), 64'(WIDTH - 5));
    checkOutput("t5_z_const", 64'(z), 64'h0000_2345);
    checkResult("t5_ignore", 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0);

    // Start in the done cycle: accepted immediately
    runOp("t5_b2b", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);

    // Reset in the middle of an operation
    @(negedge clk);
    applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_done", 64'(done), 64'd0);
    checkOutput("t6_z", 64'(z), 64'd0);
    checkOutput("t6_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    done_count = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("t6_no_done", 64'(done_count), 64'd0);
    runOp("t6_fresh", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    checkOutput("t6_z_const", 64'(z), 64'h1010_1010);

    // Random operations with corner-value bias
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = '1;
        1:       ra = '0;
        2:       ra = 32'h7FFF_FFFF;
        3:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '1;
        1:       rb = '0;
        2:       rb = 32'h7FFF_FFFF;
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      runOp("rnd", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
